fp_widen_stream: RTL
====================

// Module: fp_widen_stream
// PURPOSE
//  Streaming IEEE-754 precision widener for the SpMV value path: converts half (fp16) or single (fp32) operands to
//  double (fp64), or passes doubles through, selected per beat. LANES independent 64-bit lanes share one valid/ready
//  handshake. Pure RTL with no vendor IP; sits between the matrix-value fetch stream and the fp64 MAC.
// PARAMETERS
//  LANES      1   number of 64-bit lanes per beat (1..8)
//  MODE_W     2   width of per-beat mode field
// PORTS
//  clk        in   1          clock
//  rst        in   1          reset, synchronous, active-high
//  s_valid    in   1          input beat valid
//  s_ready    out  1          input beat accepted when s_valid&s_ready
//  s_data     in   64*LANES   lane i = s_data[64*i+:64]; fp16 in [15:0], fp32 in [31:0] of each lane
//  s_mode     in   MODE_W     0=fp16, 1=fp32, 2=fp64 passthrough, 3=reserved; sampled with the beat
//  s_last     in   1          end-of-row marker, carried to the output
//  m_valid    out  1          output beat valid
//  m_ready    in   1          downstream ready
//  m_data     out  64*LANES   fp64 results, lane-aligned
//  m_last     out  1          s_last of the source beat, asserted on its final output element only
//  m_err      out  1          source beat had mode 3 (m_data lanes forced to 0)
// BEHAVIOUR
//  - One clock, synchronous active-high reset. Reset: m_valid=0, m_last=0, m_err=0, m_data=0, s_ready=0 during rst,
//    s_ready=1 the cycle after. Reset mid-stream discards held and in-flight beats; no partial output appears afterwards.
//  - Two registers: hold reg (beat+mode+last+element index) -> output reg. Beat accepted at edge k gives its first
//    result at m_valid after edge k+1 (latency 1). Sustained 1 output element/cycle while m_ready=1.
//  - AXI-S rules: m_valid/m_data/m_last/m_err stay stable while m_valid&!m_ready; m_valid does not depend on m_ready.
//    s_ready = hold empty OR (hold on its final element AND output reg will advance). Combinational path m_ready->s_ready is allowed.
//  - Mode is latched per beat; a mode change between back-to-back beats needs no bubble.
//  - fp16 -> fp64: zero -> signed zero; normal e: exp=e+1008, frac=man<<42; subnormal (e=0, man!=0): p=msb index
//    of man, exp=p+999, frac=(man with msb cleared)<<(52-p); e=31, man=0 -> signed inf; NaN -> exp=0x7FF,
//    frac=(man<<42)|bit51 (always quieted).
//  - fp32 -> fp64: normal exp=e+896, frac=man<<29; subnormal p=msb index, exp=p+874, frac=(man w/o msb)<<(52-p);
//    inf/NaN as above with man<<29, bit51 forced.
//  - fp64 mode: lane bits copied unchanged (NaNs not quieted). Mode 3: m_data=0, m_err=1, one element, beat consumed.
//  - Sign always copied. Unused upper input bits in fp16/fp32 modes are ignored.
// CONFIGURATION
//  FP_WIDEN_PACKED_EN defined: packed input. fp16 beat carries 4 elements per lane ([15:0] first, then [31:16],[47:32],[63:48])
//   -> 4 output beats; fp32 beat carries 2 ([31:0] first) -> 2 output beats; fp64/mode 3 -> 1. Element index counter
//   in hold reg; FSM IDLE -> EMIT (idx 0..N-1) -> IDLE, or EMIT idx 0 for next beat if accepted on the final element.
//   m_last only on element N-1.
//  Not defined: one element per beat from low bits; element counter and FSM absent; 1 output beat per input beat.
// STRUCTURE
//  Package fp_widen_pkg: mode enum (FPW_HALF/FPW_SINGLE/FPW_DOUBLE/FPW_RSVD), bias constants (1008, 896, 999, 874),
//  elements-per-beat function.
//  Sub-module fp_widen_lane: combinational single-lane converter (mode, 32-bit element -> 64-bit), instanced LANES times,
//  containing the priority-encoder msb search.
// TESTING
//  1 fp16 0x3C00,0x0001,0xFC00,0x7C01 (LANES=4, one beat) -> 0x3FF0000000000000,0x3E70000000000000,
//    0xFFF0000000000000,0x7FF8040000000000; m_valid one cycle after accept.
//  2 fp32 0x3F800000,0x00000001,0x7F800001,0x80000000 -> 0x3FF0000000000000,0x36A0000000000000,
//    0x7FF8000020000000,0x8000000000000000.
//  3 mixed stream fp16/fp32/fp64/mode3 back-to-back, m_ready=1 -> 4 consecutive outputs, no bubble,
//    fp64 0x400921FB54442D18 unchanged, mode3 -> data 0 with m_err=1.
//  4 random m_ready toggling over 1000 beats -> outputs match model in order, m_data stable under stall, no loss or duplication.
//  5 rst asserted while m_valid&!m_ready with a beat held -> m_valid=0 next cycle, s_ready=1 following cycle,
//    first post-reset beat converts correctly.
//  6 (FP_WIDEN_PACKED_EN) fp16 0x4000_3C00_BC00_0000 with s_last=1 -> 4 beats 0x0,0xBFF0..,0x3FF0..,0x4000000000000000,
//    m_last only on 4th; s_ready low for the first 3 output cycles.

Source files
------------

// File: rtl/fp_widen_pkg.sv
// Shared types for the fp16/fp32 -> fp64 widener: mode encoding, exponent re-bias constants,
// and the per-beat element count (4/2/1 when packed input is enabled by FP_WIDEN_PACKED_EN).
package fp_widen_pkg;

    typedef enum logic [1:0] {
        FPW_HALF   = 2'd0,
        FPW_SINGLE = 2'd1,
        FPW_DOUBLE = 2'd2,
        FPW_RSVD   = 2'd3
    } fpw_mode_e;

    // Normal: fp64 exp = e + (1023 - src_bias). Subnormal: exp = msb_index + (1023 - src_bias - man_bits + 1).
    localparam logic [10:0] HALF_NORM_BIAS   = 11'd1008;
    localparam logic [10:0] SINGLE_NORM_BIAS = 11'd896;
    localparam logic [10:0] HALF_SUB_BIAS    = 11'd999;
    localparam logic [10:0] SINGLE_SUB_BIAS  = 11'd874;

    function automatic logic [2:0] fpw_elems(input fpw_mode_e m, input logic packed_en);
        if (!packed_en) return 3'd1;
        case (m)
            FPW_HALF:   return 3'd4;
            FPW_SINGLE: return 3'd2;
            default:    return 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/fp_widen_lane.sv
// Combinational single-lane widener: fp16/fp32 element in the low bits of word_i -> fp64,
// fp64 passthrough, reserved mode -> 0.
module fp_widen_lane
    import fp_widen_pkg::*;
(
    input  fpw_mode_e   mode_i,
    input  logic [63:0] word_i,
    output logic [63:0] res_o
);

    logic        half, sign, exp_zero, exp_max;
    logic [22:0] mant;
    logic [4:0]  msb;
    logic [51:0] frac, sub_frac;
    logic [10:0] norm_exp, sub_exp;
    logic [63:0] widened;

    always_comb begin
        half     = (mode_i == FPW_HALF);
        sign     = half ? word_i[15] : word_i[31];
        exp_zero = half ? (word_i[14:10] == 5'd0) : (word_i[30:23] == 8'd0);
        exp_max  = half ? (&word_i[14:10]) : (&word_i[30:23]);
        mant     = half ? {13'd0, word_i[9:0]} : word_i[22:0];
        frac     = half ? {word_i[9:0], 42'd0} : {word_i[22:0], 29'd0};
        norm_exp = half ? (11'(word_i[14:10]) + HALF_NORM_BIAS)
                        : (11'(word_i[30:23]) + SINGLE_NORM_BIAS);
    end

    // Priority encoder: index of the leading one of a subnormal mantissa.
    always_comb begin
        msb = 5'd0;
        for (int b = 0; b < 23; b++)
            if (mant[b]) msb = 5'(b);
    end

    always_comb begin
        sub_exp  = 11'(msb) + (half ? HALF_SUB_BIAS : SINGLE_SUB_BIAS);
        sub_frac = {29'd0, mant & ~(23'd1 << msb)} << (6'd52 - {1'b0, msb});
        if (exp_max)
            widened = {sign, 11'h7FF, (mant == 23'd0) ? 52'd0 : (frac | 52'h8_0000_0000_0000)};
        else if (exp_zero)
            widened = (mant == 23'd0) ? {sign, 63'd0} : {sign, sub_exp, sub_frac};
        else
            widened = {sign, norm_exp, frac};

        case (mode_i)
            FPW_DOUBLE: res_o = word_i;
            FPW_RSVD:   res_o = 64'd0;
            default:    res_o = widened;
        endcase
    end

endmodule

// File: rtl/fp_widen_stream.sv
// Streaming fp16/fp32/fp64 -> fp64 widener: hold register -> LANES converters -> output register.
// FP_WIDEN_PACKED_EN: each beat carries 4 (fp16) or 2 (fp32) elements per lane, emitted in order.
module fp_widen_stream
    import fp_widen_pkg::*;
#(
    parameter int LANES  = 1,
    parameter int MODE_W = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [64*LANES-1:0] s_data,
    input  logic [MODE_W-1:0]   s_mode,
    input  logic                s_last,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [64*LANES-1:0] m_data,
    output logic                m_last,
    output logic                m_err
);

`ifdef FP_WIDEN_PACKED_EN
    localparam logic PACKED = 1'b1;
`else
    localparam logic PACKED = 1'b0;
`endif
    localparam int DW = 64 * LANES;

    logic          hold_vld, out_adv, last_elem, accept, emit;
    logic [1:0]    elem_idx;
    logic [DW-1:0] hold_data_q, conv_data, out_data_q;
    fpw_mode_e     hold_mode_q;
    logic          hold_last_q, out_vld_q, out_last_q, out_err_q;

    assign out_adv   = !out_vld_q || m_ready;
    assign emit      = hold_vld && out_adv;
    assign last_elem = ({1'b0, elem_idx} == (fpw_elems(hold_mode_q, PACKED) - 3'd1));
    // A new beat may enter in the same cycle the held beat's final element leaves.
    assign s_ready   = !rst && (!hold_vld || (last_elem && out_adv));
    assign accept    = s_valid && s_ready;

`ifdef FP_WIDEN_PACKED_EN
    typedef enum logic {ST_IDLE, ST_EMIT} state_e;
    state_e     state_q, state_d;
    logic [1:0] idx_q, idx_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: if (accept) begin
                state_d = ST_EMIT;
                idx_d   = 2'd0;
            end
            ST_EMIT: if (emit) begin
                if (!last_elem)  idx_d = idx_q + 2'd1;
                else if (accept) idx_d = 2'd0;
                else             state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign hold_vld = (state_q == ST_EMIT);
    assign elem_idx = idx_q;
`else
    logic hold_vld_q, hold_vld_d;

    always_comb begin
        hold_vld_d = hold_vld_q;
        if (accept)    hold_vld_d = 1'b1;
        else if (emit) hold_vld_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) hold_vld_q <= 1'b0;
        else     hold_vld_q <= hold_vld_d;
    end

    assign hold_vld = hold_vld_q;
    assign elem_idx = 2'd0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_data_q <= '0;
            hold_mode_q <= FPW_HALF;
            hold_last_q <= 1'b0;
        end else if (accept) begin
            hold_data_q <= s_data;
            hold_mode_q <= fpw_mode_e'(s_mode[1:0]);
            hold_last_q <= s_last;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [63:0] word;
        always_comb begin
            word = hold_data_q[64*i +: 64];
            if (hold_mode_q == FPW_HALF)        word = word >> {elem_idx, 4'd0};
            else if (hold_mode_q == FPW_SINGLE) word = word >> {elem_idx[0], 5'd0};
        end
        fp_widen_lane u_lane (
            .mode_i (hold_mode_q),
            .word_i (word),
            .res_o  (conv_data[64*i +: 64])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
            out_last_q <= 1'b0;
            out_err_q  <= 1'b0;
        end else if (out_adv) begin
            out_vld_q <= hold_vld;
            if (hold_vld) begin
                out_data_q <= conv_data;
                out_last_q <= hold_last_q && last_elem;
                out_err_q  <= (hold_mode_q == FPW_RSVD);
            end
        end
    end

    assign m_valid = out_vld_q;
    assign m_data  = out_data_q;
    assign m_last  = out_last_q;
    assign m_err   = out_err_q;

endmodule
